// File: rtl/traffic_phase_scheduler.sv
// Adaptive main/side/pedestrian phase controller with yellow and all-red clearance.
// Build option: define PED_FLASH_EN to flash the walk lamp near the end of PW.
module traffic_phase_scheduler #(
  parameter int unsigned TICK_DIV  = 12000000,
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned EXT_GREEN = 2,
  parameter int unsigned MAX_GREEN = 20,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALL_RED_T = 1,
  parameter int unsigned PED_WALK  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pedButton,
  input  logic [2:0] mainTrafficIn,
  input  logic [2:0] sideTrafficIn,
  output logic       MG,
  output logic       MY,
  output logic       MR,
  output logic       SG,
  output logic       SY,
  output logic       SR,
  output logic       pedLight,
  output logic [2:0] phase
);

  localparam int PS_W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_TOP =
    PS_W'(TICK_DIV - 1);

  localparam logic [7:0] L_MIN = 8'(MIN_GREEN);
  localparam logic [7:0] L_YEL = 8'(YELLOW_T);
  localparam logic [7:0] L_AR  = 8'(ALL_RED_T);
  localparam logic [7:0] L_PW  = 8'(PED_WALK);

  typedef enum logic [2:0] {
    S_MGRN = 3'd0,
    S_MYEL = 3'd1,
    S_ARED = 3'd2,
    S_SGRN = 3'd3,
    S_SYEL = 3'd4,
    S_PW   = 3'd5
  } state_t;

  // lamp vector order: {MG,MY,MR,SG,SY,SR,ped}
  localparam logic [6:0] LMP_RST = 7'b1000010;

  logic [2:0]      r_main_s1, r_main_s2;
  logic [2:0]      r_side_s1, r_side_s2;
  logic            r_btn_s1, r_btn_s2, r_btn_d;
  logic [PS_W-1:0] r_ps;
  logic [7:0]      r_elapsed;
  logic            r_ped;
  logic            r_from_main;
  state_t          r_state;
  logic [6:0]      r_lamps;

  logic            w_tick;
  logic            w_btn_rise;
  logic            w_side_dem;
  logic            w_main_dem;
  logic            w_ped_req;
  logic [1:0]      w_dens;
  logic [9:0]      w_raw;
  logic [7:0]      w_target;
  logic [7:0]      w_el_inc;
  logic [7:0]      w_el_next;
  logic            w_chg;
  logic            w_ped_on;
  state_t          w_state_next;
  logic [6:0]      w_lamps;

  // two-flop synchronizers plus button edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_s1 <= 3'b000;
      r_main_s2 <= 3'b000;
      r_side_s1 <= 3'b000;
      r_side_s2 <= 3'b000;
      r_btn_s1  <= 1'b0;
      r_btn_s2  <= 1'b0;
      r_btn_d   <= 1'b0;
    end else begin
      r_main_s1 <= mainTrafficIn;
      r_main_s2 <= r_main_s1;
      r_side_s1 <= sideTrafficIn;
      r_side_s2 <= r_side_s1;
      r_btn_s1  <= pedButton;
      r_btn_s2  <= r_btn_s1;
      r_btn_d   <= r_btn_s2;
    end
  end

  assign w_btn_rise = r_btn_s2 & ~r_btn_d;
  assign w_side_dem = |r_side_s2;
  assign w_main_dem = |r_main_s2;
  assign w_tick     = (r_ps == PS_TOP);

  // an edge seen on the expiry tick counts in that same evaluation
  assign w_ped_req =
    r_ped | (w_btn_rise & (r_state != S_PW));

  // prescaler producing the one-cycle timing tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ps <= '0;
    end else if (w_tick) begin
      r_ps <= '0;
    end else begin
      r_ps <= r_ps + 1'b1;
    end
  end

  // density of the approach currently being served
  always_comb begin
    logic [2:0] v;
    v = (r_state == S_SGRN) ? r_side_s2 : r_main_s2;
    w_dens = {1'b0, v[0]} + {1'b0, v[1]} +
             {1'b0, v[2]};
  end

  // green target, clamped to the cap
  always_comb begin
    w_raw = 10'(MIN_GREEN) +
            10'(EXT_GREEN) * 10'(w_dens);
    if (w_raw > 10'(MAX_GREEN)) begin
      w_target = 8'(MAX_GREEN);
    end else begin
      w_target = w_raw[7:0];
    end
  end

  assign w_el_inc =
    (r_elapsed == 8'hFF) ? 8'hFF : r_elapsed + 8'd1;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_MGRN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic, evaluated only on ticks
  always_comb begin
    w_state_next = r_state;
    if (w_tick) begin
      unique case (r_state)
        S_MGRN: begin
          if (w_el_inc >= w_target &&
              (w_side_dem || w_ped_req)) begin
            w_state_next = S_MYEL;
          end
        end
        S_MYEL: begin
          if (w_el_inc >= L_YEL) begin
            w_state_next = S_ARED;
          end
        end
        S_ARED: begin
          if (w_el_inc >= L_AR) begin
            if (w_ped_req) begin
              w_state_next = S_PW;
            end else if (r_from_main) begin
              w_state_next = S_SGRN;
            end else begin
              w_state_next = S_MGRN;
            end
          end
        end
        S_SGRN: begin
          if (w_el_inc >= w_target ||
              (w_el_inc >= L_MIN && !w_side_dem)) begin
            w_state_next = S_SYEL;
          end
        end
        S_SYEL: begin
          if (w_el_inc >= L_YEL) begin
            w_state_next = S_ARED;
          end
        end
        S_PW: begin
          if (w_el_inc >= L_PW) begin
            if (r_from_main && w_side_dem) begin
              w_state_next = S_SGRN;
            end else begin
              w_state_next = S_MGRN;
            end
          end
        end
        default: w_state_next = S_MGRN;
      endcase
    end
  end

  assign w_chg = (w_state_next != r_state);

  always_comb begin
    w_el_next = r_elapsed;
    if (w_chg) begin
      w_el_next = 8'd0;
    end else if (w_tick) begin
      w_el_next = w_el_inc;
    end
  end

  // phase timer, restarts on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_elapsed <= 8'd0;
    end else begin
      r_elapsed <= w_el_next;
    end
  end

  // pedestrian request latch, consumed on entry to PW
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ped <= 1'b0;
    end else if (w_chg && w_state_next == S_PW) begin
      r_ped <= 1'b0;
    end else if (w_btn_rise && r_state != S_PW) begin
      r_ped <= 1'b1;
    end
  end

  // remembers which yellow led into all-red
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_from_main <= 1'b0;
    end else if (w_state_next == S_ARED) begin
      if (r_state == S_MYEL) begin
        r_from_main <= 1'b1;
      end else if (r_state == S_SYEL) begin
        r_from_main <= 1'b0;
      end
    end
  end

`ifdef PED_FLASH_EN
  always_comb begin
    if ({1'b0, w_el_next} + 9'd2 >= {1'b0, L_PW}) begin
      w_ped_on = ~w_el_next[0];
    end else begin
      w_ped_on = 1'b1;
    end
  end
`else
  assign w_ped_on = 1'b1;
`endif

  // FSM output decode of the upcoming state
  always_comb begin
    w_lamps = LMP_RST;
    unique case (w_state_next)
      S_MGRN:  w_lamps = 7'b1000010;
      S_MYEL:  w_lamps = 7'b0100010;
      S_ARED:  w_lamps = 7'b0010010;
      S_SGRN:  w_lamps = 7'b0011000;
      S_SYEL:  w_lamps = 7'b0010100;
      S_PW:    w_lamps = {6'b001001, w_ped_on};
      default: w_lamps = LMP_RST;
    endcase
  end

  // lamp registers switch on the same edge as the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lamps <= LMP_RST;
    end else begin
      r_lamps <= w_lamps;
    end
  end

  assign MG       = r_lamps[6];
  assign MY       = r_lamps[5];
  assign MR       = r_lamps[4];
  assign SG       = r_lamps[3];
  assign SY       = r_lamps[2];
  assign SR       = r_lamps[1];
  assign pedLight = r_lamps[0];
  assign phase    = r_state;

  logic w_unused;
  assign w_unused = w_main_dem;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: expected phase entries
// are queued by the stimulus and checked by a monitor on each phase change.
module tb_traffic_phase_scheduler;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pedButton = 1'b0;
  logic [2:0] mainT = 3'b000;
  logic [2:0] sideT = 3'b000;
  logic       MG, MY, MR, SG, SY, SR, pedLight;
  logic [2:0] phase;

  typedef struct {
    logic [2:0] ph;
    int         dur;
  } exp_t;

  exp_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .TICK_DIV (TD),
    .MAX_GREEN(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pedButton    (pedButton),
    .mainTrafficIn(mainT),
    .sideTrafficIn(sideT),
    .MG           (MG),
    .MY           (MY),
    .MR           (MR),
    .SG           (SG),
    .SY           (SY),
    .SR           (SR),
    .pedLight     (pedLight),
    .phase        (phase)
  );

  function automatic logic [6:0] lamps_of(input logic [2:0] p);
    case (p)
      3'd0:    return 7'b1000010;
      3'd1:    return 7'b0100010;
      3'd2:    return 7'b0010010;
      3'd3:    return 7'b0011000;
      3'd4:    return 7'b0010100;
      3'd5:    return 7'b0010011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string nm,
                       input int got, input int want);
    n_run++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               nm, got, want);
    end
  endtask

  task automatic expect_ph(input logic [2:0] p,
                           input int dur);
    exp_t e;
    e.ph  = p;
    e.dur = dur;
    exp_q.push_back(e);
  endtask

  // monitor: each phase change pops one expectation
  int         cyc = 0;
  logic [2:0] last_ph = 3'd0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      cyc     = 0;
      last_ph = phase;
    end else begin
      cyc++;
      if (phase !== last_ph) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transition",
                int'(phase), int'(last_ph));
        end else begin
          e = exp_q.pop_front();
          check("phase", int'(phase), int'(e.ph));
          check("lamps",
                int'({MG, MY, MR, SG, SY, SR, pedLight}),
                int'(lamps_of(e.ph)));
          check("prev_phase_cycles", cyc, e.dur * TD);
        end
        last_ph = phase;
        cyc     = 0;
      end
    end
  end

  task automatic do_reset(input logic [2:0] m,
                          input logic [2:0] s);
    @(negedge clk);
    #1 reset = 1'b1;
    mainT     = m;
    sideT     = s;
    pedButton = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input string nm, input int maxc);
    int k = 0;
    while (exp_q.size() != 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_phase(input string nm,
                            input logic [2:0] p,
                            input int maxc);
    int k = 0;
    @(negedge clk);
    while (phase !== p && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(nm, int'(phase), int'(p));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic want_flash;
    // 1: immediate reset state, then idle with no demand
    #2 reset = 1'b1;
    #1;
    check("rst_phase", int'(phase), 0);
    check("rst_lamps",
          int'({MG, MY, MR, SG, SY, SR, pedLight}),
          int'(7'b1000010));
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (45 * TD) @(negedge clk);
    check("idle_phase", int'(phase), 0);
    check("idle_mg_sr", int'({MG, SR}), 3);
    check("idle_no_events", exp_q.size(), 0);

    // 2: one side lane occupied
    do_reset(3'b000, 3'b001);
    expect_ph(3'd1, 5);
    expect_ph(3'd2, 3);
    expect_ph(3'd3, 1);
    expect_ph(3'd4, 7);
    expect_ph(3'd2, 3);
    expect_ph(3'd0, 1);
    drain("s2_done", 400);

    // 3: main green clamped at MAX_GREEN
    do_reset(3'b111, 3'b001);
    expect_ph(3'd1, 8);
    expect_ph(3'd2, 3);
    expect_ph(3'd3, 1);
    expect_ph(3'd4, 7);
    expect_ph(3'd2, 3);
    expect_ph(3'd0, 1);
    drain("s3_done", 400);

    // 4: side demand drops during side green
    do_reset(3'b000, 3'b001);
    expect_ph(3'd1, 5);
    expect_ph(3'd2, 3);
    expect_ph(3'd3, 1);
    wait_phase("s4_sgrn", 3'd3, 300);
    repeat (13) @(negedge clk);
    sideT = 3'b000;
    expect_ph(3'd4, 5);
    expect_ph(3'd2, 3);
    expect_ph(3'd0, 1);
    drain("s4_done", 300);

    // 5: pedestrian request, repeat press in walk ignored
    do_reset(3'b000, 3'b000);
    expect_ph(3'd1, 5);
    expect_ph(3'd2, 3);
    expect_ph(3'd5, 1);
    expect_ph(3'd0, 6);
    repeat (9) @(negedge clk);
    pedButton = 1'b1;
    repeat (3) @(negedge clk);
    pedButton = 1'b0;
    wait_phase("s5_pw", 3'd5, 300);
    repeat (2) @(negedge clk);
    check("walk_on", int'(pedLight), 1);
    repeat (3) @(negedge clk);
    pedButton = 1'b1;
    repeat (3) @(negedge clk);
    pedButton = 1'b0;
    repeat (14) @(negedge clk);
`ifdef PED_FLASH_EN
    want_flash = 1'b0;
`else
    want_flash = 1'b1;
`endif
    check("walk_last_tick", int'(pedLight),
          int'(want_flash));
    check("walk_last_phase", int'(phase), 5);
    drain("s5_done", 300);
    repeat (15 * TD) @(negedge clk);
    check("s5_rest_phase", int'(phase), 0);

    // 6: reset pulse in side yellow
    do_reset(3'b000, 3'b001);
    expect_ph(3'd1, 5);
    expect_ph(3'd2, 3);
    expect_ph(3'd3, 1);
    expect_ph(3'd4, 7);
    wait_phase("s6_syel", 3'd4, 400);
    drain("s6_pre", 20);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("s6_rst_phase", int'(phase), 0);
    check("s6_rst_lamps",
          int'({MG, MY, MR, SG, SY, SR, pedLight}),
          int'(7'b1000010));
    expect_ph(3'd1, 5);
    @(negedge clk);
    #1 reset = 1'b0;
    drain("s6_after", 200);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Adaptive phase controller for the main/side intersection on the iCE40 board.
- Sequences main green, side green and a pedestrian walk phase from two 3-lane sensor vectors and the ped button, with yellow and all-red clearance between phases.
- Drives the six vehicle lamps and the walk lamp directly. Sits beside the sensor input stages and replaces the fixed-time sequencing.

Parameters:
TICK_DIV, 12000000, clock cycles per timing tick (1 s at 12 MHz); benches use 4
MIN_GREEN, 5, minimum green length in ticks, both approaches
EXT_GREEN, 2, extra green ticks per occupied lane of the served approach
MAX_GREEN, 20, green length cap in ticks
YELLOW_T, 3, yellow length in ticks
ALL_RED_T, 1, all-red clearance in ticks
PED_WALK, 6, walk phase length in ticks
(all tick-count parameters must be 1..255; the phase timer is 8 bits)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
pedButton  input  1  raw pedestrian push button, asynchronous
mainTrafficIn  input  3  main-road lane sensors, one bit per lane, 1 = vehicle present
sideTrafficIn  input  3  side-road lane sensors, same encoding
MG, MY, MR  output  1 each  main green, yellow, red
SG, SY, SR  output  1 each  side green, yellow, red
pedLight  output  1  walk lamp
phase  output  3  current state code, for debug

Behaviour:
- All inputs pass through 2-flop synchronizers. Demand means the synced vector is non-zero; density is the popcount (0..3).
- Prescaler counts 0..TICK_DIV-1. It pulses tick for one cycle at TICK_DIV-1, then wraps to 0.
- elapsed (8 bits) increments on tick and clears to 0 on every state change.
- Transitions are evaluated only on tick cycles, using the post-increment elapsed value.
- Ped latch: set on a rising edge of the synced button. It clears on the cycle the FSM enters PW. Edges that occur while in PW are ignored.
- States and codes: MGRN=0, MYEL=1, ARED=2, SGRN=3, SYEL=4, PW=5. Register from_main records whether ARED was entered from MYEL (1) or from SYEL (0).
- Green target for the served approach = min(MAX_GREEN, MIN_GREEN + EXT_GREEN*density). Density is re-evaluated on every tick.
- MGRN:
  - Go to MYEL when elapsed >= target and (side demand or ped latch).
  - With no competing request, rest in MGRN indefinitely; elapsed saturates at 255.
- MYEL: go to ARED after YELLOW_T ticks, with from_main=1.
- ARED: after ALL_RED_T ticks:
  - ped latch set -> PW
  - else from_main=1 -> SGRN
  - else -> MGRN
- SGRN: go to SYEL when elapsed >= target, or when elapsed >= MIN_GREEN and side demand is 0.
- SYEL: go to ARED after YELLOW_T ticks, with from_main=0.
- PW: after PED_WALK ticks, go to SGRN if from_main=1 and side demand is set; otherwise go to MGRN. No extra all-red is needed, since PW is already all vehicle red.
- Outputs are registered Moore decodes of the next state, so lamps change on the same edge as the state. Exactly one of each G/Y/R set is high at all times.
  - MGRN: MG, SR
  - MYEL: MY, SR
  - ARED: MR, SR
  - SGRN: MR, SG
  - SYEL: MR, SY
  - PW: MR, SR, pedLight
- Reset (any time, including mid-phase): state MGRN, elapsed 0, prescaler 0, ped latch 0, from_main 0, synchronizers 0. Outputs MG=1, SR=1, all other lamps 0, phase=0. Effect is immediate, with no clock needed.
- Simultaneous events: a button edge on the same tick as MGRN expiry is seen in that same evaluation. A demand change on a tick cycle uses the value present after synchronization.

Optional Feature:
PED_FLASH_EN
- Defined: during PW, when elapsed >= PED_WALK-2, pedLight = ~elapsed[0]. With PED_WALK=6 this gives on, on, on, on, on, off per tick, then the exit.
- Undefined: pedLight is steady 1 for all of PW.
- Lamp outputs are otherwise identical in both builds.

Test Plan:
1. Reset held, then released, with both sensor vectors 0 -> MG=1, SR=1, phase=0 for more than 40 ticks; no transition.
2. side=3'b001, main=0 from reset -> MGRN held 5 ticks, MYEL 3, ARED 1, then SGRN held 7 ticks (5+2*1), SYEL 3, ARED 1, then MGRN.
3. main=3'b111, side=3'b001, MAX_GREEN=8 -> MGRN lasts 8 ticks (clamped from 11); then the side sequence as in scenario 2.
4. sideTrafficIn drops to 0 at SGRN elapsed 3 -> SGRN exits at elapsed 5 (MIN_GREEN), not at 7.
5. pedButton pulse of 3 cycles during MGRN at tick 2, no vehicle demand -> MGRN 5, MYEL 3, ARED 1, PW 6 with pedLight=1, then MGRN. A second press during PW is not served.
6. Assert reset for 1 cycle during SYEL -> same cycle MG=1, SR=1, SY=0, phase=0. A PED_FLASH_EN build run through scenario 5 shows pedLight=0 in the last PW tick.
